// File: rtl/cmp_mask_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_mask_pkg
// Brief    : Relation encodings and extension-mode constants for cmp_mask_pipe.
// Revision : 1.0
// ============================================================================
package cmp_mask_pkg;

  localparam int CMP_OP_W = 3;

  localparam logic [CMP_OP_W-1:0] CMP_OP_LT = 3'd0;
  localparam logic [CMP_OP_W-1:0] CMP_OP_LE = 3'd1;
  localparam logic [CMP_OP_W-1:0] CMP_OP_GT = 3'd2;
  localparam logic [CMP_OP_W-1:0] CMP_OP_GE = 3'd3;
  localparam logic [CMP_OP_W-1:0] CMP_OP_EQ = 3'd4;
  localparam logic [CMP_OP_W-1:0] CMP_OP_NE = 3'd5;

  localparam logic EXT_REPL = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  function automatic logic cmp_op_reserved(input logic [CMP_OP_W-1:0] op);
    return (op > CMP_OP_NE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_mask_core.sv
`default_nettype none
// ============================================================================
// Module   : cmp_mask_core
// Brief    : Combinational relation evaluator with mask extension.
// Revision : 1.0
// ============================================================================
module cmp_mask_core
  import cmp_mask_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MASK_W = 3
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic [CMP_OP_W-1:0] i_op,
  input  logic                i_signed,
  input  logic                i_ext,
  output logic                o_result,
  output logic [MASK_W-1:0]   o_mask,
  output logic                o_err
);

  logic w_eq;
  logic w_lt;
  logic w_res;
  logic w_err;
  logic [MASK_W-1:0] w_mask;

  // Only "less than" needs the signedness; every ordered relation derives from it.
  always_comb begin
    w_eq = (i_a == i_b);
    if (i_signed)
      w_lt = ($signed(i_a) < $signed(i_b));
    else
      w_lt = (i_a < i_b);
  end

  always_comb begin
    w_res = 1'b0;
    w_err = cmp_op_reserved(i_op);
    case (i_op)
      CMP_OP_LT: w_res = w_lt;
      CMP_OP_LE: w_res = w_lt | w_eq;
      CMP_OP_GT: w_res = ~(w_lt | w_eq);
      CMP_OP_GE: w_res = ~w_lt;
      CMP_OP_EQ: w_res = w_eq;
      CMP_OP_NE: w_res = ~w_eq;
      default:   w_res = 1'b0;
    endcase
  end

  always_comb begin
    w_mask = '0;
    if (i_ext == EXT_ZERO)
      w_mask[0] = w_res;
    else
      w_mask = {MASK_W{w_res}};
  end

  assign o_result = w_res;
  assign o_mask   = w_mask;
  assign o_err    = w_err;

endmodule
`default_nettype wire

// File: rtl/cmp_mask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cmp_mask_pipe
// Brief    : Single-stage valid/ready comparator producing a bit and a mask.
//            Define CMP_MASK_PIPE_HIT_CNT_EN to add a saturating hit counter.
// Revision : 1.0
// ============================================================================
module cmp_mask_pipe
  import cmp_mask_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MASK_W = 3
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [CMP_OP_W-1:0] in_op,
  input  logic                in_signed,
  input  logic                in_ext,
  input  logic                in_vld,
  output logic                in_rd,
  output logic                out_bit,
  output logic [MASK_W-1:0]   out_mask,
  output logic                out_err,
  output logic                out_vld,
  input  logic                out_rd
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0]    hit_cnt,
  input  logic                hit_cnt_clr
`endif
);

  logic              w_res;
  logic [MASK_W-1:0] w_mask;
  logic              w_err;
  logic              w_accept;
  logic              w_consume;

  logic              r_vld;
  logic              r_bit;
  logic [MASK_W-1:0] r_mask;
  logic              r_err;

  cmp_mask_core #(
    .DATA_W (DATA_W),
    .MASK_W (MASK_W)
  ) u_core (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_op     (in_op),
    .i_signed (in_signed),
    .i_ext    (in_ext),
    .o_result (w_res),
    .o_mask   (w_mask),
    .o_err    (w_err)
  );

  // Ready depends only on the output side so producers never see a vld->rd loop.
  assign in_rd     = ~r_vld | out_rd;
  assign w_accept  = in_vld & in_rd;
  assign w_consume = r_vld & out_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_bit  <= 1'b0;
      r_mask <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_bit  <= w_res;
      r_mask <= w_mask;
      r_err  <= w_err;
    end else if (w_consume) begin
      r_vld  <= 1'b0;
    end
  end

  assign out_vld  = r_vld;
  assign out_bit  = r_bit;
  assign out_mask = r_mask;
  assign out_err  = r_err;

`ifdef CMP_MASK_PIPE_HIT_CNT_EN
  logic [CNT_W-1:0] r_hit_cnt;

  // Clear has priority; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hit_cnt <= '0;
    else if (hit_cnt_clr)
      r_hit_cnt <= '0;
    else if (w_consume && r_bit && (r_hit_cnt != {CNT_W{1'b1}}))
      r_hit_cnt <= r_hit_cnt + 1'b1;
  end

  assign hit_cnt = r_hit_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_mask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_mask_pipe
// Brief    : Directed self-checking bench for cmp_mask_pipe (DATA_W=8, MASK_W=3).
// Revision : 1.0
// ============================================================================
module tb_cmp_mask_pipe;

  localparam int DW = 8;
  localparam int MW = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [2:0]    in_op;
  logic          in_signed;
  logic          in_ext;
  logic          in_vld;
  logic          in_rd;
  logic          out_bit;
  logic [MW-1:0] out_mask;
  logic          out_err;
  logic          out_vld;
  logic          out_rd;
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
  logic [1:0]    hit_cnt;
  logic          hit_cnt_clr;
`endif

  int n_vec = 0;
  int n_err = 0;

  cmp_mask_pipe #(
    .DATA_W (DW),
    .MASK_W (MW)
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_signed (in_signed),
    .in_ext    (in_ext),
    .in_vld    (in_vld),
    .in_rd     (in_rd),
    .out_bit   (out_bit),
    .out_mask  (out_mask),
    .out_err   (out_err),
    .out_vld   (out_vld),
    .out_rd    (out_rd)
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    ,
    .hit_cnt     (hit_cnt),
    .hit_cnt_clr (hit_cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; assumes out_rd=1 and an empty stage.
  task automatic xfer(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic s, input logic e,
                      input logic eb, input logic [2:0] em, input logic ee);
    in_a = a; in_b = b; in_op = op; in_signed = s; in_ext = e; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    check({tag, ".vld"},  32'(out_vld),  32'd1);
    check({tag, ".bit"},  32'(out_bit),  32'(eb));
    check({tag, ".mask"}, 32'(out_mask), 32'(em));
    check({tag, ".err"},  32'(out_err),  32'(ee));
  endtask

  // Back-to-back stream: {a, b, op, signed, ext} and hand-computed {bit, mask}.
  logic [7:0] s_a  [8] = '{8'h03, 8'h03, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h42, 8'h42};
  logic [7:0] s_b  [8] = '{8'h07, 8'h07, 8'h01, 8'h01, 8'h80, 8'h80, 8'h42, 8'h43};
  logic [2:0] s_op [8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd5};
  logic       s_sg [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       s_ex [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       e_bt [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0] e_mk [8] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b001, 3'b000, 3'b001, 3'b111};

  initial begin
    rst_n = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_signed = 1'b0;
    in_ext = 1'b0; in_vld = 1'b0; out_rd = 1'b1;
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    hit_cnt_clr = 1'b0;
`endif
    #1;
    check("rst.vld",  32'(out_vld),  32'd0);
    check("rst.bit",  32'(out_bit),  32'd0);
    check("rst.mask", 32'(out_mask), 32'd0);
    check("rst.err",  32'(out_err),  32'd0);
    check("rst.in_rd", 32'(in_rd),   32'd1);
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    check("rst.hit",  32'(hit_cnt),  32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xfer("lt_u",   8'h05, 8'h80, 3'd0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("lt_s",   8'h05, 8'h80, 3'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    xfer("ge_s_z", 8'h05, 8'h80, 3'd3, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
    xfer("gt_u_z", 8'h80, 8'h05, 3'd2, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
    xfer("le_s",   8'h80, 8'h05, 3'd1, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("le_eq",  8'hFF, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("rsv6",   8'h11, 8'h11, 3'd6, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    xfer("rsv7",   8'h11, 8'h11, 3'd7, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    xfer("eq",     8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("ne",     8'h11, 8'h11, 3'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    check("drain.vld", 32'(out_vld), 32'd0);

    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("strm%0d.vld", i-1),  32'(out_vld),  32'd1);
        check($sformatf("strm%0d.bit", i-1),  32'(out_bit),  32'(e_bt[i-1]));
        check($sformatf("strm%0d.mask", i-1), 32'(out_mask), 32'(e_mk[i-1]));
      end
      if (i < 8) begin
        check($sformatf("strm%0d.in_rd", i), 32'(in_rd), 32'd1);
        in_a = s_a[i]; in_b = s_b[i]; in_op = s_op[i];
        in_signed = s_sg[i]; in_ext = s_ex[i]; in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
      @(negedge clk);
    end
    check("strm.end_vld", 32'(out_vld), 32'd0);

    out_rd = 1'b0;
    in_a = 8'h01; in_b = 8'h02; in_op = 3'd0; in_signed = 1'b0; in_ext = 1'b0; in_vld = 1'b1;
    @(negedge clk);
    in_a = 8'h02; in_b = 8'h01;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d.in_rd", i), 32'(in_rd),    32'd0);
      check($sformatf("stall%0d.vld", i),   32'(out_vld),  32'd1);
      check($sformatf("stall%0d.bit", i),   32'(out_bit),  32'd1);
      check($sformatf("stall%0d.mask", i),  32'(out_mask), 32'b111);
      @(negedge clk);
    end
    out_rd = 1'b1;
    #1;
    check("release.in_rd", 32'(in_rd), 32'd1);
    @(negedge clk);
    in_vld = 1'b0;
    check("release.vld",  32'(out_vld),  32'd1);
    check("release.bit",  32'(out_bit),  32'd0);
    check("release.mask", 32'(out_mask), 32'b000);
    @(negedge clk);
    check("release.drain", 32'(out_vld), 32'd0);
    in_a = 8'hAA; in_b = 8'h55; in_op = 3'd4;
    @(negedge clk);
    in_op = 3'd5;
    @(negedge clk);
    check("idle.vld", 32'(out_vld), 32'd0);

`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    hit_cnt_clr = 1'b1;
    @(negedge clk);
    hit_cnt_clr = 1'b0;
    check("hit.clr0", 32'(hit_cnt), 32'd0);
    xfer("hit_a", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("hit_b", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    @(negedge clk);
    check("hit.two", 32'(hit_cnt), 32'd2);
    xfer("hit_c", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("hit_d", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    xfer("hit_e", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    @(negedge clk);
    check("hit.sat", 32'(hit_cnt), 32'd3);
    xfer("hit_f", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    hit_cnt_clr = 1'b1;
    @(negedge clk);
    hit_cnt_clr = 1'b0;
    check("hit.clr_win", 32'(hit_cnt), 32'd0);
    xfer("hit_g", 8'h11, 8'h11, 3'd5, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    check("hit.false", 32'(hit_cnt), 32'd0);
    xfer("hit_h", 8'h11, 8'h11, 3'd4, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    @(negedge clk);
    check("hit.one", 32'(hit_cnt), 32'd1);
`endif

    out_rd = 1'b0;
    in_a = 8'h01; in_b = 8'h02; in_op = 3'd0; in_signed = 1'b0; in_ext = 1'b0; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    check("mid.vld_before", 32'(out_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid.vld",   32'(out_vld),  32'd0);
    check("mid.bit",   32'(out_bit),  32'd0);
    check("mid.in_rd", 32'(in_rd),    32'd1);
`ifdef CMP_MASK_PIPE_HIT_CNT_EN
    check("mid.hit",   32'(hit_cnt),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_rd = 1'b1;
    @(negedge clk);
    check("post.vld", 32'(out_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
